memoria_tabuleiro: RTL and testbench
====================================

Name: memoria_tabuleiro

Overview:
- Board store for both players, 16 rows x 12 cells each.
- Serves whole 36-bit rows to the scoring logic: the scorer drives `enderecoMemo` and reads back `dadosA`/`dadosB`.
- Write side:
  - a row-load port places ships;
  - a shot handshake runs a read-modify-write on one cell and returns hit/miss/repeat/invalid.
- Sits between the game controller (loads and shots) and the scoring block (reads).

Parameters:
- LINHAS, 16, rows per board; address width is clog2(LINHAS) = 4.
- COLUNAS, 12, cells per row.
- BITS_CELULA, 3, bits per cell; row width is COLUNAS*BITS_CELULA = 36.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- enderecoMemo  in  4  read row address from the scorer.
- dadosA  out  36  player A row at enderecoMemo, registered.
- dadosB  out  36  player B row at enderecoMemo, registered.
- cargaEn  in  1  row-load strobe.
- cargaJogador  in  1  0 = board A, 1 = board B.
- cargaLinha  in  4  row to load.
- cargaDados  in  36  row contents.
- cargaOk  out  1  one-cycle pulse: load accepted.
- tiroValid  in  1  shot request.
- tiroReady  out  1  block can accept a shot.
- tiroJogador  in  1  target board: 0 = A, 1 = B.
- tiroLinha  in  4  target row.
- tiroColuna  in  4  target column.
- resultadoValid  out  1  one-cycle result pulse.
- resultado  out  2  00 agua, 01 acerto, 10 repetido, 11 invalido.

Behaviour:
- Cell encoding: cell c occupies row bits [3c+2:3c].
  - Bit 2 = shot flag.
  - Bits 1:0 = content: 00 agua, 01 submarino, 10 destroier, 11 porta-avioes.
- Reset:
  - every cell of both boards cleared to 0;
  - dadosA = dadosB = 0, resultado = 0;
  - resultadoValid = 0, cargaOk = 0, tiroReady = 1;
  - FSM goes to OCIOSO.
  - Reset mid-shot abandons the shot: no write, no result pulse.
- Read port: dadosA/dadosB are valid 1 cycle after enderecoMemo.
  - Read-before-write: a same-cycle write to the addressed row appears on the following read.
- FSM states: OCIOSO, LER, ESCREVER, RESPONDER.
  - OCIOSO: tiroReady = 1. When tiroValid is high, latch jogador/linha/coluna and go to LER.
  - LER: tiroReady = 0. Capture the target row into a working register. Go to ESCREVER.
  - ESCREVER, result rules:
    - coluna >= COLUNAS (12..15) or linha >= LINHAS: result invalido, no write.
    - shot flag already set: result repetido, no write.
    - content = 00: result agua; set the flag and write the row back.
    - content != 00: result acerto; set the flag and write the row back.
    - Go to RESPONDER.
  - RESPONDER: resultadoValid = 1 for exactly one cycle, resultado held until the next result. Return to OCIOSO; tiroReady rises the same cycle.
- Shot latency: accept at cycle T, write at T+2, resultadoValid at T+3. The next shot can be accepted at T+3.
- Load port:
  - Accepted only in OCIOSO with tiroValid = 0. The row is written at the next edge and cargaOk pulses that cycle.
  - Outside those conditions the load is ignored and no cargaOk is produced. The controller retries.
  - A load overwrites the shot flags in that row.
- Simultaneous cargaEn and tiroValid in OCIOSO: the shot wins and the load is dropped.
- A shot on board A never alters board B, and vice versa.

Decomposition:
- Package `batalha_pkg` holds:
  - LINHAS, COLUNAS, BITS_CELULA;
  - cell content constants AGUA / SUBMARINO / DESTROIER / PORTA_AVIOES;
  - resultado codes AGUA / ACERTO / REPETIDO / INVALIDO;
  - FSM state typedef.
- One natural sub-module, `avalia_celula` (combinational). Inputs: row, column. Outputs: result code and updated row.
- The storage array stays in the top block.

Test Plan:
- Reset then read every address: dadosA = dadosB = 0 for enderecoMemo = 0..15. tiroReady = 1 and resultadoValid never pulses.
- Load board A, row 3, with 36'h000000001 (submarino at column 0), then read address 3: cargaOk pulses once, dadosA = 36'h000000001 one cycle later, dadosB = 0.
- Shot A(3,0) after that load: resultadoValid at T+3 with resultado = 01; subsequent read of row 3 gives dadosA = 36'h000000005.
- Repeat shot A(3,0): resultado = 10, row unchanged (36'h000000005). Shot A(3,1): resultado = 00, row becomes 36'h000000025.
- Shot B(0,13): resultado = 11, no row of board B changes. Shot with reset asserted at T+1: no resultadoValid, row unchanged, tiroReady = 1 after reset.
- cargaEn and tiroValid asserted together in OCIOSO: the shot completes, cargaOk stays 0, the load row is unchanged. cargaEn during LER is ignored.

Source files
------------

// File: rtl/batalha_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | batalha_pkg                                                          |
// | Shared board geometry, cell/result encodings and shot FSM states.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package batalha_pkg;

   localparam int LINHAS      = 16;
   localparam int COLUNAS     = 12;
   localparam int BITS_CELULA = 3;
   localparam int LARG_LINHA  = COLUNAS * BITS_CELULA;
   localparam int LARG_END    = $clog2(LINHAS);

   localparam logic [1:0] CEL_AGUA         = 2'b00;
   localparam logic [1:0] CEL_SUBMARINO    = 2'b01;
   localparam logic [1:0] CEL_DESTROIER    = 2'b10;
   localparam logic [1:0] CEL_PORTA_AVIOES = 2'b11;

   localparam logic [1:0] RES_AGUA     = 2'b00;
   localparam logic [1:0] RES_ACERTO   = 2'b01;
   localparam logic [1:0] RES_REPETIDO = 2'b10;
   localparam logic [1:0] RES_INVALIDO = 2'b11;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      LER       = 2'd1,
      ESCREVER  = 2'd2,
      RESPONDER = 2'd3
   } estado_t;

endpackage
`default_nettype wire

// File: rtl/avalia_celula.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | avalia_celula                                                        |
// | Classifies a shot on one cell of a row and builds the flagged row.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module avalia_celula
   import batalha_pkg::*;
(
   input  logic [LARG_LINHA-1:0] i_linha,
   input  logic [3:0]            i_coluna,
   output logic [1:0]            o_resultado,
   output logic [LARG_LINHA-1:0] o_linha_nova
);

   // Row is zero-extended to 16 cells so columns 12..15 index safely.
   localparam int LARG_EXT = 16 * BITS_CELULA;

   logic [LARG_EXT-1:0]    w_ext;
   logic [5:0]             w_idx;
   logic [BITS_CELULA-1:0] w_celula;

   always_comb begin
      w_ext        = LARG_EXT'(i_linha);
      w_idx        = 6'(i_coluna) * 6'(BITS_CELULA);
      w_celula     = w_ext[w_idx +: BITS_CELULA];
      o_linha_nova = i_linha | ({{(LARG_LINHA-1){1'b0}}, 1'b1} << (w_idx + 6'd2));
      if ({1'b0, i_coluna} >= 5'(COLUNAS))
         o_resultado = RES_INVALIDO;
      else if (w_celula[2])
         o_resultado = RES_REPETIDO;
      else if (w_celula[1:0] == CEL_AGUA)
         o_resultado = RES_AGUA;
      else
         o_resultado = RES_ACERTO;
   end

endmodule
`default_nettype wire

// File: rtl/memoria_tabuleiro.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memoria_tabuleiro                                                    |
// | Two-player board store: row reads, row loads, read-modify-write shot.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module memoria_tabuleiro
   import batalha_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [LARG_END-1:0]   enderecoMemo,
   output logic [LARG_LINHA-1:0] dadosA,
   output logic [LARG_LINHA-1:0] dadosB,
   input  logic                  cargaEn,
   input  logic                  cargaJogador,
   input  logic [LARG_END-1:0]   cargaLinha,
   input  logic [LARG_LINHA-1:0] cargaDados,
   output logic                  cargaOk,
   input  logic                  tiroValid,
   output logic                  tiroReady,
   input  logic                  tiroJogador,
   input  logic [LARG_END-1:0]   tiroLinha,
   input  logic [3:0]            tiroColuna,
   output logic                  resultadoValid,
   output logic [1:0]            resultado
);

   estado_t               estado_q, estado_d;
   logic [LARG_LINHA-1:0] mem_a_q [LINHAS];
   logic [LARG_LINHA-1:0] mem_a_d [LINHAS];
   logic [LARG_LINHA-1:0] mem_b_q [LINHAS];
   logic [LARG_LINHA-1:0] mem_b_d [LINHAS];
   logic [LARG_LINHA-1:0] dados_a_q, dados_a_d;
   logic [LARG_LINHA-1:0] dados_b_q, dados_b_d;
   logic [LARG_LINHA-1:0] trab_q, trab_d;
   logic                  jog_q, jog_d;
   logic [LARG_END-1:0]   lin_q, lin_d;
   logic [3:0]            col_q, col_d;
   logic [1:0]            res_q, res_d;
   logic                  carga_ok_q, carga_ok_d;

   logic                  w_aceita;
   logic                  w_linha_valida;
   logic [1:0]            w_res_cel;
   logic [1:0]            w_res;
   logic [LARG_LINHA-1:0] w_linha_nova;

   avalia_celula u_avalia (
      .i_linha      (trab_q),
      .i_coluna     (col_q),
      .o_resultado  (w_res_cel),
      .o_linha_nova (w_linha_nova)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         mem_a_q    <= '{default: '0};
         mem_b_q    <= '{default: '0};
         dados_a_q  <= '0;
         dados_b_q  <= '0;
         trab_q     <= '0;
         jog_q      <= 1'b0;
         lin_q      <= '0;
         col_q      <= '0;
         res_q      <= '0;
         carga_ok_q <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         mem_a_q    <= mem_a_d;
         mem_b_q    <= mem_b_d;
         dados_a_q  <= dados_a_d;
         dados_b_q  <= dados_b_d;
         trab_q     <= trab_d;
         jog_q      <= jog_d;
         lin_q      <= lin_d;
         col_q      <= col_d;
         res_q      <= res_d;
         carga_ok_q <= carga_ok_d;
      end
   end

   // RESPONDER already accepts the next shot so back-to-back shots lose no cycle.
   assign w_aceita = tiroValid && (estado_q == OCIOSO || estado_q == RESPONDER);

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCIOSO:    if (w_aceita) estado_d = LER;
         LER:       estado_d = ESCREVER;
         ESCREVER:  estado_d = RESPONDER;
         RESPONDER: estado_d = w_aceita ? LER : OCIOSO;
         default:   estado_d = OCIOSO;
      endcase
   end

   always_comb begin
      w_linha_valida = ({1'b0, lin_q} < (LARG_END + 1)'(LINHAS));
      w_res          = w_linha_valida ? w_res_cel : RES_INVALIDO;

      mem_a_d    = mem_a_q;
      mem_b_d    = mem_b_q;
      dados_a_d  = mem_a_q[enderecoMemo];
      dados_b_d  = mem_b_q[enderecoMemo];
      trab_d     = trab_q;
      jog_d      = jog_q;
      lin_d      = lin_q;
      col_d      = col_q;
      res_d      = res_q;
      carga_ok_d = 1'b0;

      if (w_aceita) begin
         jog_d = tiroJogador;
         lin_d = tiroLinha;
         col_d = tiroColuna;
      end

      if (estado_q == OCIOSO && cargaEn && !tiroValid) begin
         carga_ok_d = 1'b1;
         if (cargaJogador) mem_b_d[cargaLinha] = cargaDados;
         else              mem_a_d[cargaLinha] = cargaDados;
      end

      if (estado_q == LER)
         trab_d = jog_q ? mem_b_q[lin_q] : mem_a_q[lin_q];

      if (estado_q == ESCREVER) begin
         res_d = w_res;
         if (w_res == RES_AGUA || w_res == RES_ACERTO) begin
            if (jog_q) mem_b_d[lin_q] = w_linha_nova;
            else       mem_a_d[lin_q] = w_linha_nova;
         end
      end
   end

   always_comb begin
      tiroReady      = (estado_q == OCIOSO) || (estado_q == RESPONDER);
      resultadoValid = (estado_q == RESPONDER);
      resultado      = res_q;
      dadosA         = dados_a_q;
      dadosB         = dados_b_q;
      cargaOk        = carga_ok_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_memoria_tabuleiro.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memoria_tabuleiro                                                 |
// | Directed self-checking bench for the board store.                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_memoria_tabuleiro;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  enderecoMemo;
   logic [35:0] dadosA, dadosB;
   logic        cargaEn, cargaJogador;
   logic [3:0]  cargaLinha;
   logic [35:0] cargaDados;
   logic        cargaOk;
   logic        tiroValid, tiroReady, tiroJogador;
   logic [3:0]  tiroLinha, tiroColuna;
   logic        resultadoValid;
   logic [1:0]  resultado;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   memoria_tabuleiro dut (
      .clk            (clk),
      .reset          (reset),
      .enderecoMemo   (enderecoMemo),
      .dadosA         (dadosA),
      .dadosB         (dadosB),
      .cargaEn        (cargaEn),
      .cargaJogador   (cargaJogador),
      .cargaLinha     (cargaLinha),
      .cargaDados     (cargaDados),
      .cargaOk        (cargaOk),
      .tiroValid      (tiroValid),
      .tiroReady      (tiroReady),
      .tiroJogador    (tiroJogador),
      .tiroLinha      (tiroLinha),
      .tiroColuna     (tiroColuna),
      .resultadoValid (resultadoValid),
      .resultado      (resultado)
   );

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ler(input logic [3:0] a, input logic [35:0] exp_a, input logic [35:0] exp_b);
      enderecoMemo = a;
      tick();
      chk($sformatf("dadosA[%0d]", a), dadosA, exp_a);
      chk($sformatf("dadosB[%0d]", a), dadosB, exp_b);
   endtask

   task automatic carga(input logic j, input logic [3:0] l, input logic [35:0] d);
      cargaEn = 1'b1; cargaJogador = j; cargaLinha = l; cargaDados = d;
      tick();
      cargaEn = 1'b0;
      chk("cargaOk pulse", 36'(cargaOk), 36'd1);
      tick();
      chk("cargaOk end", 36'(cargaOk), 36'd0);
   endtask

   // Shot accepted at the first edge; result expected in the third cycle after.
   task automatic tiro(input logic j, input logic [3:0] l, input logic [3:0] c, input logic [1:0] exp);
      chk("tiroReady before", 36'(tiroReady), 36'd1);
      tiroValid = 1'b1; tiroJogador = j; tiroLinha = l; tiroColuna = c;
      tick();
      tiroValid = 1'b0; cargaEn = 1'b0;
      chk("T+1 valid", 36'(resultadoValid), 36'd0);
      chk("T+1 ready", 36'(tiroReady), 36'd0);
      chk("T+1 cargaOk", 36'(cargaOk), 36'd0);
      tick();
      chk("T+2 valid", 36'(resultadoValid), 36'd0);
      tick();
      chk("T+3 valid", 36'(resultadoValid), 36'd1);
      chk("T+3 resultado", 36'(resultado), 36'(exp));
      tick();
      chk("T+4 valid", 36'(resultadoValid), 36'd0);
      chk("T+4 ready", 36'(tiroReady), 36'd1);
      chk("T+4 resultado held", 36'(resultado), 36'(exp));
   endtask

   initial begin
      reset = 1'b1; enderecoMemo = '0;
      cargaEn = 1'b0; cargaJogador = 1'b0; cargaLinha = '0; cargaDados = '0;
      tiroValid = 1'b0; tiroJogador = 1'b0; tiroLinha = '0; tiroColuna = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst tiroReady", 36'(tiroReady), 36'd1);
      chk("rst resultadoValid", 36'(resultadoValid), 36'd0);
      chk("rst cargaOk", 36'(cargaOk), 36'd0);
      chk("rst resultado", 36'(resultado), 36'd0);
      for (int i = 0; i < 16; i++) begin
         ler(4'(i), 36'h0, 36'h0);
         chk("rst no pulse", 36'(resultadoValid), 36'd0);
      end

      carga(1'b0, 4'd3, 36'h000000001);
      ler(4'd3, 36'h000000001, 36'h0);

      tiro(1'b0, 4'd3, 4'd0, 2'b01);
      ler(4'd3, 36'h000000005, 36'h0);
      tiro(1'b0, 4'd3, 4'd0, 2'b10);
      ler(4'd3, 36'h000000005, 36'h0);
      tiro(1'b0, 4'd3, 4'd1, 2'b00);
      ler(4'd3, 36'h000000025, 36'h0);

      carga(1'b1, 4'd0, 36'h000000003);
      tiro(1'b1, 4'd0, 4'd13, 2'b11);
      ler(4'd0, 36'h0, 36'h000000003);
      tiro(1'b1, 4'd0, 4'd0, 2'b01);
      ler(4'd0, 36'h0, 36'h000000007);
      ler(4'd3, 36'h000000025, 36'h0);

      // Reloading a row clears its shot flags.
      carga(1'b0, 4'd3, 36'h000000002);
      ler(4'd3, 36'h000000002, 36'h0);

      // Reset one cycle after acceptance: shot abandoned.
      tiroValid = 1'b1; tiroJogador = 1'b0; tiroLinha = 4'd3; tiroColuna = 4'd2;
      tick();
      tiroValid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort ready", 36'(tiroReady), 36'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort no pulse", 36'(resultadoValid), 36'd0);
      end
      ler(4'd3, 36'h0, 36'h0);

      // Load and shot together: the shot wins.
      cargaEn = 1'b1; cargaJogador = 1'b0; cargaLinha = 4'd3; cargaDados = 36'h000000007;
      tiro(1'b0, 4'd3, 4'd0, 2'b00);
      chk("dropped load cargaOk", 36'(cargaOk), 36'd0);
      ler(4'd3, 36'h000000004, 36'h0);

      // Load during LER is ignored.
      tiroValid = 1'b1; tiroJogador = 1'b0; tiroLinha = 4'd4; tiroColuna = 4'd0;
      tick();
      tiroValid = 1'b0;
      cargaEn = 1'b1; cargaJogador = 1'b0; cargaLinha = 4'd4; cargaDados = 36'h000000001;
      tick();
      cargaEn = 1'b0;
      chk("LER load cargaOk", 36'(cargaOk), 36'd0);
      tick();
      chk("LER load valid", 36'(resultadoValid), 36'd1);
      chk("LER load resultado", 36'(resultado), 36'd0);
      tick();
      chk("LER load cargaOk end", 36'(cargaOk), 36'd0);
      ler(4'd4, 36'h000000004, 36'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
